// File: rtl/ifm_read_responder.sv
`default_nettype none
// ifm_read_responder: IFM buffer read responder with 2-stage read pipeline and ordered response FIFO.
// Optional macro IFM_RSP_BYPASS_EN enables same-cycle write-to-read forwarding.
module ifm_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    input  logic                  done_in,
    output logic                  drained,
    output logic                  addr_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [FAW+1:0] FD = (FAW+2)'(FIFO_DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic                  ready_en;
    logic                  idle_done;
    logic [DATA_WIDTH-1:0] mem  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
    logic [FAW-1:0]        wr_ptr, rd_ptr;
    logic [FAW:0]          count;

    logic                  s1_valid, s1_oor, s1_hit;
    logic [AW-1:0]         s1_idx;
    logic [DATA_WIDTH-1:0] s1_hold;

    logic [AW-1:0]         req_idx, wr_idx;
    logic                  req_oor, wr_oor, req_mis, wr_ok, hit;
    logic                  accept, push, pop, empty, bad;
    logic [FAW+1:0]        occ;
    logic [DATA_WIDTH-1:0] hold_data, read_data;
    logic                  unused_bits;

    assign req_idx = req_addr[AW+1:2];
    assign wr_idx  = wr_addr[AW+1:2];
    assign req_oor = (req_addr >> (AW + 2)) != 32'd0;
    assign wr_oor  = (wr_addr  >> (AW + 2)) != 32'd0;
    assign req_mis = req_addr[1:0] != 2'b00;
    assign wr_ok   = wr_en && !wr_oor;
    assign hit     = wr_ok && !req_oor && (wr_idx == req_idx);
    assign unused_bits = ^wr_addr[1:0];

    // Credit check counts the address-stage entry so the FIFO can never overflow.
    assign occ       = {1'b0, count} + {{(FAW+1){1'b0}}, s1_valid};
    assign req_ready = ready_en && (state != DRAIN) && (occ < FD);
    assign accept    = req_valid && req_ready;
    assign push      = s1_valid;
    assign rsp_valid = count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? fifo[rd_ptr] : '0;
    assign empty     = (count == '0) && !s1_valid;
    assign drained   = ((state == DRAIN) && empty) || idle_done;
    assign bad       = (accept && (req_oor || req_mis)) || (wr_en && wr_oor);

    // The memory is read one cycle after accept, so a colliding write has already landed;
    // the value to return on a collision is captured at accept time instead.
`ifdef IFM_RSP_BYPASS_EN
    assign hold_data = wr_data;
`else
    assign hold_data = mem[req_idx];
`endif
    assign read_data = s1_oor ? '0 : (s1_hit ? s1_hold : mem[s1_idx]);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= read_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_hit   <= 1'b0;
            s1_idx   <= '0;
            s1_hold  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_idx  <= req_idx;
                s1_oor  <= req_oor;
                s1_hit  <= hit;
                s1_hold <= hold_data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FAW{1'b0}}, push} - {{FAW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            idle_done <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            ready_en  <= 1'b1;
            idle_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept)       state     <= RUN;
                    else if (done_in) idle_done <= 1'b1;
                end
                RUN:     if (done_in) state <= DRAIN;
                DRAIN:   if (empty)   state <= IDLE;
                default: state <= IDLE;
            endcase
            // A new run starts with a clean flag unless its own first request is bad.
            if ((state == IDLE) && accept) addr_err <= bad;
            else if (bad)                  addr_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifm_read_responder.sv
`default_nettype none
// tb_ifm_read_responder: directed scoreboard bench for ifm_read_responder (DEPTH 256, FIFO_DEPTH 4).
module tb_ifm_read_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        done_in = 1'b0;
    logic        drained;
    logic        addr_err;

    always #5 clk = ~clk;

    ifm_read_responder #(.DATA_WIDTH(32), .DEPTH(256), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .done_in(done_in), .drained(drained), .addr_err(addr_err)
    );

    logic [31:0] model [256];
    logic [31:0] exp_q [$];
    int total = 0, passed = 0, failed = 0;
    int cycle = 0, nacc = 0, drained_cnt = 0, drained_cyc = -1;
    int last_pop_cyc = -1, first_rsp_cyc = -1, c0 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; score pops, push expectations, update model.
    task automatic cyc();
        logic [31:0] e;
        #1;
        if (drained) begin drained_cnt++; drained_cyc = cycle; end
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else chk("rsp_data", rsp_data, exp_q.pop_front());
            if (first_rsp_cyc < 0) first_rsp_cyc = cycle;
            last_pop_cyc = cycle;
        end
        if (req_valid && req_ready) begin
            nacc++;
            e = (req_addr >= 32'd1024) ? 32'd0 : model[req_addr[9:2]];
`ifdef IFM_RSP_BYPASS_EN
            if (wr_en && wr_addr < 32'd1024 && req_addr < 32'd1024 && wr_addr[9:2] == req_addr[9:2])
                e = wr_data;
`endif
            exp_q.push_back(e);
        end
        if (wr_en && wr_addr < 32'd1024) model[wr_addr[9:2]] = wr_data;
        cycle++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        req_valid = 1'b1; req_addr = a;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        cyc();
        done_in = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_drained", {31'd0, drained}, 32'd0);
        chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("ready_after_edge", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 4; i++) wr(32'(4 * i), 32'hA0 + 32'(i));
        wr(32'h10, 32'h11);
        wr(32'h14, 32'h1234_5678);

        // Back-to-back reads, latency and ordering
        first_rsp_cyc = -1;
        c0 = cycle;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin req_addr = 32'(4 * i); cyc(); end
        req_valid = 1'b0;
        idle(4);
        chk("first_latency", 32'(first_rsp_cyc - c0), 32'd2);
        chk("consecutive", 32'(last_pop_cyc - first_rsp_cyc), 32'd3);

        // Backpressure: only FIFO_DEPTH accepts, then ordered drain
        rsp_ready = 1'b0;
        nacc = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin req_addr = 32'(4 * (i % 4)); cyc(); end
        req_valid = 1'b0;
        chk("bp_accepts", 32'(nacc), 32'd4);
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        idle(6);
        chk("bp_drained_all", 32'(exp_q.size()), 32'd0);

        // Same-cycle write and read of one word
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h55;
        req_valid = 1'b1; req_addr = 32'h10;
        cyc();
        wr_en = 1'b0; req_valid = 1'b0;
        idle(3);
        rd(32'h10);
        idle(3);

        // done_in with three responses outstanding
        rsp_ready = 1'b0;
        rd(32'h0); rd(32'h4); rd(32'h8);
        drained_cnt = 0;
        pulse_done();
        chk("drain_ready_low", {31'd0, req_ready}, 32'd0);
        rsp_ready = 1'b1;
        idle(6);
        chk("drain_pulses", 32'(drained_cnt), 32'd1);
        chk("drain_after_pop", 32'(drained_cyc - last_pop_cyc), 32'd1);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // done_in while idle
        drained_cnt = 0;
        c0 = cycle;
        pulse_done();
        idle(3);
        chk("idle_done_pulses", 32'(drained_cnt), 32'd1);
        chk("idle_done_delay", 32'(drained_cyc - c0), 32'd1);

        // Out-of-range and misaligned requests, sticky error
        chk("err_clear", {31'd0, addr_err}, 32'd0);
        rd(32'h402);
        idle(3);
        chk("err_oor", {31'd0, addr_err}, 32'd1);
        rd(32'h6);
        idle(3);
        pulse_done();
        idle(4);
        chk("err_sticky_idle", {31'd0, addr_err}, 32'd1);
        rd(32'h4);
        idle(3);
        chk("err_cleared_run", {31'd0, addr_err}, 32'd0);
        pulse_done();
        idle(4);
        wr(32'h800, 32'hDEAD_BEEF);
        chk("err_oor_write", {31'd0, addr_err}, 32'd1);

        // Reset with two requests in flight
        rd(32'h0); rd(32'h4);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_addr_err", {31'd0, addr_err}, 32'd0);
        exp_q.delete();
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        rd(32'h14);
        rd(32'h0);
        idle(4);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
